// File: rtl/bit_serial_adder.sv
// Bit-serial N-bit adder built around a single full_adder cell.
// Operands are captured on an accepted start pulse, then one bit pair is
// added per clock, LSB first, with the carry recirculated through a flop.

// Single-bit full adder cell shared by the combinational and sequential labs.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Carry
);

    assign Sum   = A ^ B ^ Cin;
    assign Carry = (A & B) | (Cin & (A ^ B));

endmodule

module bit_serial_adder #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t         state;
    logic [N-1:0]   a_sr;
    logic [N-1:0]   b_sr;
    logic [N-1:0]   s_sr;
    logic           carry_ff;
    logic [CW-1:0]  cnt;
    logic           fa_sum;
    logic           fa_carry;

    full_adder u_fa (
        .A     (a_sr[0]),
        .B     (b_sr[0]),
        .Cin   (carry_ff),
        .Sum   (fa_sum),
        .Carry (fa_carry)
    );

    // Control FSM plus datapath registers; busy/done are registered so they
    // line up exactly with the SHIFT and DONE states.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            s_sr     <= '0;
            carry_ff <= 1'b0;
            cnt      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        a_sr     <= a;
                        b_sr     <= b;
                        carry_ff <= cin;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    s_sr     <= {fa_sum, s_sr[N-1:1]};
                    carry_ff <= fa_carry;
                    a_sr     <= {1'b0, a_sr[N-1:1]};
                    b_sr     <= {1'b0, b_sr[N-1:1]};
                    cnt      <= cnt + CW'(1);
                    if (cnt == LAST_BIT) begin
                        sum   <= {fa_sum, s_sr[N-1:1]};
                        cout  <= fa_carry;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Testbench for bit_serial_adder: scoreboard of expected {cout,sum} values
// computed with plain arithmetic, popped by a monitor on every done pulse.
module tb_bit_serial_adder;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;

    logic         start4 = 1'b0;
    logic [3:0]   a4 = '0;
    logic [3:0]   b4 = '0;
    logic         cin4 = 1'b0;
    logic         busy4;
    logic         done4;
    logic [3:0]   sum4;
    logic         cout4;

    int           tests = 0;
    int           errors = 0;
    int           doneCount = 0;
    logic [N:0]   expQ[$];
    logic [N:0]   lastExp = '0;

    bit_serial_adder #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    bit_serial_adder #(.N(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Reference arithmetic: the full (N+1)-bit sum of both operands and carry-in.
    function automatic logic [N:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                         input logic c);
        return {1'b0, x} + {1'b0, y} + (N+1)'(c);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on each done pulse and otherwise checks
    // that the registered result holds its last value.
    always @(negedge clk) begin
        checkOutput("busy_done_exclusive", 32'(busy & done), 32'd0);
        if (rst) begin
            lastExp = '0;
        end else if (done) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [N:0] e;
                e = expQ.pop_front();
                checkOutput("result", 32'({cout, sum}), 32'(e));
                lastExp = e;
                doneCount++;
            end
        end else begin
            checkOutput("hold", 32'({cout, sum}), 32'(lastExp));
        end
    end

    // Issues one operation from IDLE and returns in the cycle done is high.
    task automatic applyStimulus(input logic [N-1:0] x, input logic [N-1:0] y,
                                 input logic c);
        int cycles;
        logic busyBad;
        a = x;
        b = y;
        cin = c;
        start = 1'b1;
        expQ.push_back(model(x, y, c));
        @(posedge clk);
        #1;
        start = 1'b0;
        a = N'($urandom);
        b = N'($urandom);
        cin = 1'($urandom);
        cycles = 0;
        busyBad = 1'b0;
        while (!done && cycles < N + 4) begin
            if (!busy) busyBad = 1'b1;
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput("latency", 32'(cycles), 32'(N));
        checkOutput("busy_during_shift", 32'(busyBad), 32'd0);
        checkOutput("busy_in_done", 32'(busy), 32'd0);
    endtask

    task automatic runOp(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
        applyStimulus(x, y, c);
        @(posedge clk);
        #1;
        checkOutput("done_single_cycle", 32'(done), 32'd0);
    endtask

    // Global watchdog so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [N:0] prior;
        int d0;
        int cycles4;

        #1;
        checkOutput("reset_sum", 32'(sum), 32'd0);
        checkOutput("reset_cout", 32'(cout), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] directed operations");
        runOp(8'h5A, 8'h3C, 1'b0);
        runOp(8'hFF, 8'h01, 1'b0);
        runOp(8'hFF, 8'hFF, 1'b1);
        runOp(8'h00, 8'h00, 1'b0);
        runOp(8'h00, 8'h00, 1'b1);

        $display("[TB] random operations");
        for (int i = 0; i < 20; i++) begin
            runOp(N'($urandom), N'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end

        $display("[TB] start held high with changing operands");
        @(posedge clk);
        #1;
        d0 = doneCount;
        a = 8'h10;
        b = 8'h20;
        cin = 1'b0;
        start = 1'b1;
        for (int k = 0; k < 2 * (N + 2); k++) begin
            if (k % (N + 2) == 0) expQ.push_back(model(a, b, cin));
            @(posedge clk);
            #1;
            a = N'($urandom);
            b = N'($urandom);
        end
        start = 1'b0;
        repeat (N + 3) @(posedge clk);
        #1;
        checkOutput("held_start_done_count", 32'(doneCount - d0), 32'd2);

        $display("[TB] start only in DONE cycle");
        applyStimulus(8'h21, 8'h43, 1'b1);
        prior = model(8'h21, 8'h43, 1'b1);
        a = 8'hEE;
        b = 8'h77;
        cin = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("done_start_busy", 32'(busy), 32'd0);
        checkOutput("done_start_done", 32'(done), 32'd0);
        checkOutput("done_start_hold", 32'({cout, sum}), 32'(prior));
        runOp(8'h12, 8'h34, 1'b0);

        $display("[TB] reset mid-operation");
        a = 8'hAA;
        b = 8'h55;
        cin = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("abort_sum", 32'(sum), 32'd0);
        checkOutput("abort_cout", 32'(cout), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (N + 3) @(posedge clk);
        #1;
        checkOutput("abort_no_done", 32'(done), 32'd0);
        runOp(8'h01, 8'h01, 1'b0);
        checkOutput("after_abort_result", 32'({cout, sum}), 32'h002);

        $display("[TB] N=4 instance");
        a4 = 4'hF;
        b4 = 4'h1;
        cin4 = 1'b0;
        start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        cycles4 = 0;
        while (!done4 && cycles4 < 10) begin
            @(posedge clk);
            #1;
            cycles4++;
        end
        checkOutput("n4_latency", 32'(cycles4), 32'd4);
        checkOutput("n4_sum", 32'(sum4), 32'h0);
        checkOutput("n4_cout", 32'(cout4), 32'd1);
        checkOutput("n4_busy_in_done", 32'(busy4), 32'd0);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
